// File: rtl/relm_fp_pack_if.sv
// Valid/ready bundle linking the custom-op result registers, the pack stage and writeback.
interface relm_fp_pack_if #(
    parameter int WD = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [WD-1:0] in_a;
    logic [WD-1:0] in_b;
    logic          out_valid;
    logic          out_ready;
    logic [WD-1:0] out_data;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/relm_fp_pack.sv
// Normalize/round/pack stage: turns the FADD/FMUL intermediate (flag word + unnormalized
// mantissa with sticky bit) into a packed binary32 word, one operation at a time.
module relm_fp_pack #(
    parameter int WD     = 32,
    parameter int COARSE = 8
) (
    input  logic          clk,
    input  logic          reset,
    relm_fp_pack_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_NORM  = 2'd1;
    localparam logic [1:0] S_ROUND = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    localparam logic signed [9:0] E_ONE    = 10'sd1;
    localparam logic signed [9:0] E_COARSE = 10'(COARSE);

    logic [1:0]        state_q, state_d;
    logic [WD-1:0]     res_q, res_d;
    logic              sign_q, sign_d;
    logic signed [9:0] e_q, e_d;
    logic [WD-1:0]     m_q, m_d;
    logic [WD-1:0]     m_step;
    logic signed [9:0] e_step;
    logic              unused_flag_bits;

    assign unused_flag_bits = ^bus.in_b[20:0];

    function automatic logic [31:0] special_pack(input logic s, input logic inf, input logic zero);
        if (inf && zero) return {s, 8'hFF, 1'b1, 22'd0};
        if (inf)         return {s, 8'hFF, 23'd0};
        return {s, 31'd0};
    endfunction

    // Round-to-nearest-even on a mantissa whose hidden one sits at bit 30.
    function automatic logic [31:0] round_pack(input logic s, input logic signed [9:0] e,
                                               input logic [29:0] m);
        logic              inc;
        logic [23:0]       mant_r;
        logic signed [9:0] e_r;
        inc    = m[6] & ((|m[5:0]) | m[7]);
        mant_r = {1'b0, m[29:7]} + {23'd0, inc};
        e_r    = mant_r[23] ? e + E_ONE : e;
        if (e_r <= 10'sd0)   return {s, 31'd0};
        if (e_r >= 10'sd255) return {s, 8'hFF, 23'd0};
        return {s, e_r[7:0], mant_r[22:0]};
    endfunction

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        sign_d  = sign_q;
        e_d     = e_q;
        m_d     = m_q;
        m_step  = m_q;
        e_step  = e_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    sign_d = bus.in_b[31];
                    e_d    = {2'b00, bus.in_b[30:23]};
                    m_d    = bus.in_a;
                    if (bus.in_b[22] || bus.in_b[21]) begin
                        res_d   = special_pack(bus.in_b[31], bus.in_b[22], bus.in_b[21]);
                        state_d = S_OUT;
                    end else begin
                        state_d = S_NORM;
                    end
                end
            end
            S_NORM: begin
                if (m_q == '0) begin
                    res_d   = '0;
                    state_d = S_OUT;
                end else begin
                    if (m_q[31]) begin
                        m_step = {1'b0, m_q[31:2], m_q[1] | m_q[0]};
                        e_step = e_q + E_ONE;
                    end else if (m_q[30]) begin
                        m_step = m_q;
                        e_step = e_q;
                    end else if (m_q[30:22] == '0) begin
                        m_step = m_q << COARSE;
                        e_step = e_q - E_COARSE;
                    end else begin
                        m_step = m_q << 1;
                        e_step = e_q - E_ONE;
                    end
                    m_d = m_step;
                    e_d = e_step;
                    // A step that lands the hidden one on bit 30 hands straight to ROUND.
                    if (e_step <= 10'sd0) begin
                        res_d   = {sign_q, 31'd0};
                        state_d = S_OUT;
                    end else if (m_step[30]) begin
                        state_d = S_ROUND;
                    end
                end
            end
            S_ROUND: begin
                res_d   = round_pack(sign_q, e_q, m_q[29:0]);
                state_d = S_OUT;
            end
            default: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
        end
    end

    // Datapath operands are always reloaded on accept, so they carry no reset.
    always_ff @(posedge clk) begin
        sign_q <= sign_d;
        e_q    <= e_d;
        m_q    <= m_d;
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_OUT);
    assign bus.out_data  = res_q;
endmodule

// File: tb/tb_relm_fp_pack.sv
// Bench for relm_fp_pack: directed cases plus random operations against a value-level model.
module tb_relm_fp_pack;
    localparam int COARSE = 8;

    logic clk = 1'b0;
    logic reset;
    int   errors;
    int   checks;

    relm_fp_pack_if #(.WD(32)) bus ();

    relm_fp_pack #(.WD(32), .COARSE(COARSE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_b(input logic s, input int e, input logic inf, input logic zero);
        return {s, e[7:0], inf, zero, 21'd0};
    endfunction

    // Value = M * 2^(E-157); round the exact value to 24 significant bits, nearest-even.
    function automatic logic [31:0] ref_pack(input logic [31:0] b, input logic [31:0] a);
        logic   s;
        int     e_in, p, k, ef;
        longint sig, rem, half;
        s    = b[31];
        e_in = int'(b[30:23]);
        if (b[22] && b[21]) return {s, 8'hFF, 1'b1, 22'd0};
        if (b[22])          return {s, 8'hFF, 23'd0};
        if (b[21])          return {s, 31'd0};
        if (a == 32'd0)     return 32'd0;
        p = 31;
        while (a[p] == 1'b0) p--;
        ef = e_in + p - 30;
        if (ef <= 0) return {s, 31'd0};
        k = p - 23;
        if (k <= 0) begin
            sig = longint'(a) << (-k);
        end else begin
            sig  = longint'(a) >> k;
            rem  = longint'(a) & ((64'sd1 << k) - 64'sd1);
            half = 64'sd1 << (k - 1);
            if (rem > half || (rem == half && sig[0])) sig++;
        end
        if (sig == (64'sd1 << 24)) begin
            sig = sig >> 1;
            ef++;
        end
        if (ef >= 255) return {s, 8'hFF, 23'd0};
        return {s, 8'(ef), sig[22:0]};
    endfunction

    // Edges after the accept edge until out_valid shows; -1 where the flush point is not modelled.
    function automatic int ref_lat(input logic [31:0] b, input logic [31:0] a);
        int p, n;
        if (b[22] || b[21]) return 0;
        if (a == 32'd0)     return 1;
        p = 31;
        while (a[p] == 1'b0) p--;
        if (int'(b[30:23]) + p - 30 <= 0) return -1;
        if (p >= 30) return 2;
        n = 0;
        while (p <= 21) begin
            p += COARSE;
            n++;
        end
        n += 30 - p;
        return n + 1;
    endfunction

    task automatic run_op(input string tag, input logic [31:0] b, input logic [31:0] a,
                          input int exp_lat, input logic [31:0] exp_data, input int hold);
        int lat;
        @(negedge clk);
        check({tag, ":in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_b     = b;
        bus.in_a     = a;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (exp_lat >= 0) check({tag, ":lat"}, 32'(lat), 32'(exp_lat));
        else              check({tag, ":lat_bound"}, 32'(lat <= 10), 32'd1);
        check({tag, ":data"}, bus.out_data, exp_data);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, ":hold_data"}, bus.out_data, exp_data);
            check({tag, ":hold_in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        check({tag, ":handoff_in_ready"}, 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, ":released"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = 32'd0;
        bus.in_b      = 32'd0;
        bus.out_ready = 1'b0;

        @(negedge clk);
        check("rst:in_ready", 32'(bus.in_ready), 32'd1);
        check("rst:out_valid", 32'(bus.out_valid), 32'd0);
        check("rst:out_data", bus.out_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("one",      mk_b(0, 127, 0, 0), 32'h40000000, 2,  32'h3F800000, 5);
        run_op("carry",    mk_b(0, 127, 0, 0), 32'h80000000, 2,  32'h40000000, 0);
        run_op("ovf",      mk_b(0, 254, 0, 0), 32'h80000000, 2,  32'h7F800000, 0);
        run_op("tie_even", mk_b(0, 127, 0, 0), 32'h40000040, 2,  32'h3F800000, 0);
        run_op("tie_odd",  mk_b(0, 127, 0, 0), 32'h400000C0, 2,  32'h3F800002, 1);
        run_op("mcarry",   mk_b(0, 127, 0, 0), 32'h7FFFFFC0, 2,  32'h40000000, 0);
        run_op("uflow",    mk_b(1, 1, 0, 0),   32'h20000000, 1,  32'h80000000, 0);
        run_op("zero_m",   mk_b(1, 127, 0, 0), 32'h00000000, 1,  32'h00000000, 0);
        run_op("nan",      mk_b(1, 127, 1, 1), 32'h12345678, 0,  32'hFFC00000, 0);
        run_op("inf",      mk_b(0, 127, 1, 0), 32'h12345678, 0,  32'h7F800000, 0);
        run_op("zflag",    mk_b(1, 127, 0, 1), 32'h12345678, 0,  32'h80000000, 2);
        run_op("worst",    mk_b(0, 127, 0, 0), 32'h00000001, 10, 32'h30800000, 0);

        // Abort a long normalization with an asynchronous reset pulse.
        @(negedge clk);
        bus.in_b     = mk_b(0, 127, 0, 0);
        bus.in_a     = 32'h00000001;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("mid:out_valid", 32'(bus.out_valid), 32'd0);
        reset = 1'b1;
        #1;
        check("mid_rst:in_ready", 32'(bus.in_ready), 32'd1);
        check("mid_rst:out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst:out_data", bus.out_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op("post_rst", mk_b(0, 127, 0, 0), 32'h400000C0, 2, 32'h3F800002, 0);

        for (int t = 0; t < 40; t++) begin
            logic [31:0] rb, ra;
            int          sel, ev;
            sel = int'($urandom_range(0, 9));
            ev  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                               : int'($urandom_range(100, 160));
            rb  = mk_b(1'($urandom_range(0, 1)), ev, sel == 0 || sel == 2, sel == 1 || sel == 2);
            ra  = $urandom >> $urandom_range(0, 31);
            run_op($sformatf("rnd%0d", t), rb, ra, ref_lat(rb, ra), ref_pack(rb, ra),
                   int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
